ss_ctrl: RTL and testbench
==========================

# ss_ctrl

Test sequencer for the sequence-signal test path: runs the 16-bit sequence generator and the "10110" sequence detector as one automated self-check. It clears the detector, loads the generator, shifts the pattern out for a programmable number of passes, and counts detector hits. It then reports pass/fail against an expected hit count. It sits beside the generator/detector pair at top level and drives their load/enable/clear controls.

## Interface
- SEQ_LEN, 16, bits shifted per pass (generator length).
- DRAIN_CYC, 2, post-shift wait cycles for detector latency (≥1).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  run request, sampled only in IDLE.
- abort  in  1  cancel the run in progress.
- loops  in  4  number of pattern passes; 0 treated as 1.
- exp_hits  in  8  expected detector hit count.
- seq_jug  in  1  detector hit flag, one cycle per hit.
- gen_load  out  1  generator parallel load, high for the LOAD cycle.
- gen_en  out  1  generator shift enable, high in SHIFT.
- det_clr  out  1  detector state clear, high in CLR.
- busy  out  1  high in every state except IDLE.
- done  out  1  registered one-cycle completion pulse.
- pass  out  1  registered result: hit_cnt == exp_hits.
- hit_cnt  out  8  hits counted this run, saturating.
- state  out  3  FSM state code.

## Operation
- State codes: IDLE=0, CLR=1, LOAD=2, SHIFT=3, DRAIN=4, CHECK=5. Codes 6 and 7 return to IDLE on the next edge.
- IDLE + start=1:
  - Latch loops (0→1) into loops_q and exp_hits into exp_q.
  - Clear hit_cnt, pass, pass index and bit counter.
  - Go to CLR.
- CLR: det_clr=1 for one cycle, then LOAD.
- LOAD: gen_load=1 for one cycle, bit counter cleared, then SHIFT.
- SHIFT: gen_en=1 while the bit counter runs 0..SEQ_LEN-1. At SEQ_LEN-1:
  - If pass index == loops_q-1, go to DRAIN.
  - Otherwise increment the pass index and go to LOAD. The generator is reloaded every pass.
- DRAIN: wait DRAIN_CYC cycles, then CHECK.
- CHECK: one cycle. On the edge leaving CHECK: pass<=(hit_cnt==exp_q), done<=1, go to IDLE.
- Hit counting: hit_cnt increments by one when seq_jug=1 in LOAD, SHIFT or DRAIN, and saturates at 255. seq_jug is ignored in IDLE, CLR and CHECK.
- Control outputs (gen_load, gen_en, det_clr, busy, state) are Moore decodes of the state register.
- pass and hit_cnt hold their values after done until the next start is accepted.
- start while busy is ignored; it is not queued.
- abort=1 in any busy state:
  - Go to IDLE on the next edge.
  - done stays 0 and pass<=0; hit_cnt holds.
  - abort is ignored in IDLE.
- Priority: rst_n > abort > normal transitions.

## Timing
- Reset (rst_n=0 at an edge) gives state=IDLE with every output 0, all counters 0, and loops_q=1, exp_q=0. This holds mid-run too; the run is discarded.
- Cycle count from the start-accept edge to the done edge: 1 + loops_q·(SEQ_LEN+1) + DRAIN_CYC + 1.
  - Defaults with loops=1: done rises at the 21st edge after the accept edge.
  - Default with loops=3: done rises at the 55th edge.
- done is high for exactly one cycle and coincides with the first IDLE cycle. pass is valid in the same cycle.
- A start in the done cycle is accepted. The new run clears pass and hit_cnt at that edge, and done falls.
- gen_en is high for exactly loops_q·SEQ_LEN cycles per run. Each run of gen_en is preceded by exactly one gen_load cycle.
- A seq_jug on the last DRAIN cycle is counted. That count is included in the pass comparison.

## Test plan
- Reset, then loops=1 and exp_hits=2; bench pulses seq_jug twice during SHIFT -> 1 CLR, 1 LOAD, 16 gen_en cycles; done at edge 21; hit_cnt=2, pass=1.
- loops=3, exp_hits=5; bench drives 4 hits -> 3 gen_load pulses, 48 gen_en cycles; done at edge 55; hit_cnt=4, pass=0.
- loops=0 -> behaves exactly as loops=1; done at edge 21.
- seq_jug held high for the whole run, exp_hits=255, loops=15 -> hit_cnt saturates at 255, pass=1.
- abort asserted on SHIFT cycle 5 -> IDLE next edge; busy=0, done never pulses, pass=0. A second start while busy earlier in the run is ignored.
- rst_n=0 during DRAIN -> all outputs 0 at that edge. start in the done cycle of a prior run -> new run accepted immediately and hit_cnt cleared.

Source files
------------

// File: rtl/ss_ctrl.sv
// Sequencer for the generator/detector self-test: clears the detector, reloads and shifts the generator, counts hits.
// Latency: done pulses 1 + loops*(SEQ_LEN+1) + DRAIN_CYC + 1 edges after the start-accept edge.
// Backpressure: none; start is only taken in IDLE, is never queued, and abort cancels a run from any busy state.
module ss_ctrl #(
  parameter int SEQ_LEN   = 16,
  parameter int DRAIN_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] loops,
  input  logic [7:0] exp_hits,
  input  logic       seq_jug,
  output logic       gen_load,
  output logic       gen_en,
  output logic       det_clr,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] hit_cnt,
  output logic [2:0] state
);

  localparam int BW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
  localparam int DW = $clog2(DRAIN_CYC + 1);

  localparam logic [BW-1:0] BIT_LAST   = BW'(SEQ_LEN - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYC - 1);

  // Plain codes rather than an enum so the unused codes 6/7 stay representable.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLR   = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_CHECK = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [3:0]    loops_q, loops_d;
  logic [7:0]    exp_q, exp_d;
  logic [3:0]    pidx_q, pidx_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [7:0]    hit_q, hit_d;
  logic          pass_q, pass_d;
  logic          done_q, done_d;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      loops_q <= 4'd1;
      exp_q   <= '0;
      pidx_q  <= '0;
      bit_q   <= '0;
      drain_q <= '0;
      hit_q   <= '0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      loops_q <= loops_d;
      exp_q   <= exp_d;
      pidx_q  <= pidx_d;
      bit_q   <= bit_d;
      drain_q <= drain_d;
      hit_q   <= hit_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Next-state, counters and result; abort overrides everything but reset.
  always_comb begin
    state_d = state_q;
    loops_d = loops_q;
    exp_d   = exp_q;
    pidx_d  = pidx_q;
    bit_d   = bit_q;
    drain_d = '0;
    hit_d   = hit_q;
    pass_d  = pass_q;
    done_d  = 1'b0;

    // Hits are only meaningful while the pattern is in flight through the detector.
    if ((state_q == S_LOAD || state_q == S_SHIFT || state_q == S_DRAIN) &&
        seq_jug && (hit_q != 8'hFF)) begin
      hit_d = hit_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          loops_d = (loops == 4'd0) ? 4'd1 : loops;
          exp_d   = exp_hits;
          hit_d   = '0;
          pass_d  = 1'b0;
          pidx_d  = '0;
          bit_d   = '0;
        end
      end
      S_CLR: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          bit_d = '0;
          if (pidx_q == loops_q - 4'd1) begin
            state_d = S_DRAIN;
          end else begin
            pidx_d  = pidx_q + 4'd1;
            state_d = S_LOAD;
          end
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          state_d = S_CHECK;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      S_CHECK: begin
        state_d = S_IDLE;
        pass_d  = (hit_q == exp_q);
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A cancelled run reports no result and freezes the hit count.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
      done_d  = 1'b0;
      hit_d   = hit_q;
    end
  end

  // Moore decodes of the state register plus registered results.
  always_comb begin
    gen_load = (state_q == S_LOAD);
    gen_en   = (state_q == S_SHIFT);
    det_clr  = (state_q == S_CLR);
    busy     = (state_q != S_IDLE);
    state    = state_q;
    done     = done_q;
    pass     = pass_q;
    hit_cnt  = hit_q;
  end

endmodule

// File: tb/tb_ss_ctrl.sv
// Bench for ss_ctrl: directed runs with hand-computed results, checked by a queue-based monitor.
// Timing: done edge is checked against the absolute edge count expected from the accept edge.
// Abort, reset mid-run, ignored start while busy and restart in the done cycle are exercised directly.
module tb_ss_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [3:0] loops;
  logic [7:0] exp_hits;
  logic       seq_jug;
  logic       gen_load;
  logic       gen_en;
  logic       det_clr;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] hit_cnt;
  logic [2:0] state;

  ss_ctrl #(.SEQ_LEN(16), .DRAIN_CYC(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .loops    (loops),
    .exp_hits (exp_hits),
    .seq_jug  (seq_jug),
    .gen_load (gen_load),
    .gen_en   (gen_en),
    .det_clr  (det_clr),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .hit_cnt  (hit_cnt),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hits;
    int pss;
    int cyc;
    int loads;
    int ens;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   n_load = 0;
  int   n_en   = 0;
  int   n_clr  = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp_v, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: counts control pulses per run and scores each done pulse against the queue.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && busy) begin
      if (gen_load) n_load++;
      if (gen_en)   n_en++;
      if (det_clr)  n_clr++;
    end
    if (done) begin
      done_cnt++;
      chk("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("run_hit_cnt", int'(hit_cnt), e.hits);
        chk("run_pass", int'(pass), e.pss);
        chk("run_done_edge", cyc, e.cyc);
        chk("run_gen_load_cnt", n_load, e.loads);
        chk("run_gen_en_cnt", n_en, e.ens);
        chk("run_det_clr_cnt", n_clr, 1);
        chk("run_busy_in_done", int'(busy), 0);
      end
    end
    if (!busy) begin
      n_load = 0;
      n_en   = 0;
      n_clr  = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raises start for one edge; optionally pushes the expected result of that run.
  task automatic issue_start(input int l, input int e, input int h, input int p,
                             input int lds, input int ens, input int off, input bit push);
    exp_t x;
    start    = 1'b1;
    loops    = 4'(l);
    exp_hits = 8'(e);
    if (push) begin
      x.hits  = h;
      x.pss   = p;
      x.cyc   = cyc + 1 + off;
      x.loads = lds;
      x.ens   = ens;
      sb.push_back(x);
    end
    tick();
    start = 1'b0;
  endtask

  // Single-cycle hits, spaced out, inside the first SHIFT pass.
  task automatic drive_hits(input int n);
    repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      seq_jug = 1'b1;
      tick();
      seq_jug = 1'b0;
      tick();
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (n < budget && !seen) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      n++;
    end
    chk("done_seen", int'(seen), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_hit_cnt"}, int'(hit_cnt), 0);
    chk({tag, "_gen_en"}, int'(gen_en), 0);
    chk({tag, "_gen_load"}, int'(gen_load), 0);
    chk({tag, "_det_clr"}, int'(det_clr), 0);
  endtask

  initial begin
    int d0;
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    loops    = 4'd0;
    exp_hits = 8'd0;
    seq_jug  = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // loops=1, two hits, expect 2 -> pass; done 21 edges after accept
    issue_start(1, 2, 2, 1, 1, 16, 21, 1'b1);
    drive_hits(2);
    wait_done(100);
    repeat (3) @(negedge clk);
    chk("hold_hit_cnt", int'(hit_cnt), 2);
    chk("hold_pass", int'(pass), 1);
    chk("hold_done_low", int'(done), 0);
    tick();

    // loops=3, four hits against 5 expected -> fail; done at 55
    issue_start(3, 5, 4, 0, 3, 48, 55, 1'b1);
    drive_hits(4);
    wait_done(200);
    tick();

    // loops=0 behaves as loops=1
    issue_start(0, 0, 0, 1, 1, 16, 21, 1'b1);
    wait_done(100);
    tick();

    // seq_jug held high, loops=15: 257 counting cycles saturate at 255
    seq_jug = 1'b1;
    issue_start(15, 255, 255, 1, 15, 240, 259, 1'b1);
    wait_done(400);
    seq_jug = 1'b0;
    tick();

    // abort on SHIFT cycle 5, with an ignored start during LOAD
    issue_start(2, 9, 0, 0, 0, 0, 0, 1'b0);
    tick();
    start = 1'b1;
    tick();
    start   = 1'b0;
    seq_jug = 1'b1;
    tick();
    seq_jug = 1'b0;
    repeat (4) tick();
    abort = 1'b1;
    @(negedge clk);
    chk("pre_abort_state", int'(state), 3);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_state", int'(state), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pass", int'(pass), 0);
    chk("abort_hit_hold", int'(hit_cnt), 1);
    d0 = done_cnt;
    repeat (70) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    chk("abort_no_requeue", int'(state), 0);
    tick();

    // reset during DRAIN discards the run
    issue_start(1, 3, 0, 0, 0, 0, 0, 1'b0);
    drive_hits(1);
    repeat (13) tick();
    @(negedge clk);
    chk("pre_reset_state", int'(state), 4);
    chk("pre_reset_hits", int'(hit_cnt), 1);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("midrun_reset");
    rst_n = 1'b1;
    tick();

    // start in the done cycle is accepted and clears the result
    issue_start(1, 1, 1, 1, 1, 16, 21, 1'b1);
    drive_hits(1);
    wait_done(100);
    issue_start(1, 0, 0, 1, 1, 16, 21, 1'b1);
    @(negedge clk);
    chk("restart_state", int'(state), 1);
    chk("restart_hit_cnt", int'(hit_cnt), 0);
    chk("restart_pass", int'(pass), 0);
    chk("restart_done", int'(done), 0);
    wait_done(100);
    repeat (3) tick();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
